// File: rtl/ripple_count_ctrl.sv
// rtl/ripple_count_ctrl.sv - measurement sequencer for the 8-bit ripple counter
// Clears the counter, gates it for a programmed window, settles, then captures a stable count.
module ripple_count_ctrl #(
  parameter int WIDTH   = 8,
  parameter int WIN_W   = 16,
  parameter int SETTLE  = 2,
  parameter int MAX_TRY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_clr,
  output logic             cnt_gate,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             unstable
);

  localparam int ST_W  = $clog2(SETTLE + 1);
  localparam int TRY_W = $clog2(MAX_TRY + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_GATE   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [ST_W-1:0]  set_q, set_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             unstable_q, unstable_d;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    set_d      = set_q;
    try_d      = try_q;
    prev_d     = prev_q;
    first_d    = first_q;
    result_d   = result_q;
    unstable_d = unstable_q;
    // Abort takes priority so that an abort during SAMPLE never captures a result.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            win_d   = (window == '0) ? WIN_W'(1) : window;
            state_d = S_CLEAR;
          end
        end
        S_CLEAR: state_d = S_GATE;
        S_GATE: begin
          if (win_q <= WIN_W'(1)) begin
            state_d = S_SETTLE;
            set_d   = ST_W'(SETTLE);
          end else begin
            win_d = win_q - 1'b1;
          end
        end
        S_SETTLE: begin
          if (set_q <= ST_W'(1)) begin
            state_d = S_SAMPLE;
            first_d = 1'b1;
            try_d   = '0;
          end else begin
            set_d = set_q - 1'b1;
          end
        end
        S_SAMPLE: begin
          // cnt_q may be mid-ripple; only two equal consecutive samples are trusted.
          if (first_q) begin
            prev_d  = cnt_q;
            first_d = 1'b0;
          end else if (cnt_q == prev_q) begin
            result_d   = cnt_q;
            unstable_d = 1'b0;
            state_d    = S_HOLD;
          end else if (try_q == TRY_W'(MAX_TRY - 1)) begin
            result_d   = cnt_q;
            unstable_d = 1'b1;
            state_d    = S_HOLD;
          end else begin
            prev_d = cnt_q;
            try_d  = try_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (result_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      set_q      <= '0;
      try_q      <= '0;
      prev_q     <= '0;
      first_q    <= 1'b0;
      result_q   <= '0;
      unstable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      set_q      <= set_d;
      try_q      <= try_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      result_q   <= result_d;
      unstable_q <= unstable_d;
    end
  end

  assign cnt_clr      = (state_q == S_CLEAR);
  assign cnt_gate     = (state_q == S_GATE);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_HOLD);
  assign result       = result_q;
  assign unstable     = unstable_q;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// tb/tb_ripple_count_ctrl.sv - directed self-checking bench for ripple_count_ctrl
// A behavioural ripple-counter model feeds cnt_q; each task checks one scenario.
module tb_ripple_count_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] window;
  logic [7:0]  cnt_model;
  logic        cnt_clr;
  logic        cnt_gate;
  logic        busy;
  logic [7:0]  result;
  logic        result_valid;
  logic        result_ready;
  logic        unstable;
  logic        unstable_mode;

  int total;
  int bad;

  ripple_count_ctrl #(
    .WIDTH(8), .WIN_W(16), .SETTLE(2), .MAX_TRY(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .window(window),
    .cnt_q(cnt_model),
    .cnt_clr(cnt_clr),
    .cnt_gate(cnt_gate),
    .busy(busy),
    .result(result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .unstable(unstable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: one count per gated cycle; in unstable mode it keeps moving every cycle.
  always @(posedge clk) begin
    if (cnt_clr) cnt_model <= 8'd0;
    else if (cnt_gate || unstable_mode) cnt_model <= cnt_model + 8'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; abort = 1'b0; window = 16'd0;
    result_ready = 1'b0; unstable_mode = 1'b0; cnt_model = 8'd0;
    tick; tick;
    total++; if ({cnt_clr, cnt_gate, busy, result_valid, unstable} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {cnt_clr, cnt_gate, busy, result_valid, unstable});
    end
    total++; if (result !== 8'd0) begin
      bad++; $display("FAIL reset_result: got %0h want 0", result);
    end
    reset = 1'b1;
    tick;
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_basic;
    int gfirst, glast, gcnt, clr_late, vfirst, vcnt;
    logic [7:0] vres;
    logic vuns;
    gfirst = -1; glast = -1; gcnt = 0; clr_late = 0; vfirst = -1; vcnt = 0;
    vres = 8'hxx; vuns = 1'bx;
    result_ready = 1'b1; unstable_mode = 1'b0;
    window = 16'd10; start = 1'b1;
    tick;
    start = 1'b0; window = 16'd3;
    total++; if ({cnt_clr, busy, cnt_gate} !== 3'b110) begin
      bad++; $display("FAIL basic_e0: clr/busy/gate got %b want 110", {cnt_clr, busy, cnt_gate});
    end
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (cnt_gate) begin
        if (gfirst < 0) gfirst = k;
        glast = k; gcnt++;
      end
      if (cnt_clr) clr_late++;
      if (result_valid) begin
        vcnt++;
        if (vfirst < 0) begin vfirst = k; vres = result; vuns = unstable; end
      end
    end
    total++; if (gfirst !== 1 || glast !== 10) begin
      bad++; $display("FAIL basic_gate_span: got %0d..%0d want 1..10", gfirst, glast);
    end
    total++; if (gcnt !== 10) begin
      bad++; $display("FAIL basic_gate_len: got %0d want 10", gcnt);
    end
    total++; if (clr_late !== 0) begin
      bad++; $display("FAIL basic_clr_once: extra clr cycles %0d want 0", clr_late);
    end
    total++; if (vfirst !== 15) begin
      bad++; $display("FAIL basic_valid_edge: got E%0d want E15", vfirst);
    end
    total++; if (vres !== 8'h0A || vuns !== 1'b0) begin
      bad++; $display("FAIL basic_result: got %0h/%b want 0a/0", vres, vuns);
    end
    total++; if (vcnt !== 1) begin
      bad++; $display("FAIL basic_valid_len: got %0d want 1", vcnt);
    end
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL basic_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_zero_window;
    int gcnt, vfirst;
    gcnt = 0; vfirst = -1;
    result_ready = 1'b1;
    window = 16'd0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      if (cnt_gate) gcnt++;
      if (result_valid && vfirst < 0) vfirst = k;
    end
    total++; if (gcnt !== 1) begin
      bad++; $display("FAIL zero_gate_len: got %0d want 1", gcnt);
    end
    total++; if (vfirst !== 6) begin
      bad++; $display("FAIL zero_valid_edge: got E%0d want E6", vfirst);
    end
    total++; if (result !== 8'd1) begin
      bad++; $display("FAIL zero_result: got %0h want 1", result);
    end
  endtask

  task automatic test_backpressure;
    int vk, hold_bad;
    vk = -1; hold_bad = 0;
    result_ready = 1'b0;
    window = 16'd2; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 30 && vk < 0; k++) begin
      tick;
      if (result_valid) vk = k;
    end
    total++; if (vk !== 7) begin
      bad++; $display("FAIL bp_valid_edge: got E%0d want E7", vk);
    end
    total++; if (result !== 8'd2) begin
      bad++; $display("FAIL bp_result: got %0h want 2", result);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin start = 1'b1; window = 16'd5; end
      tick;
      start = 1'b0;
      if (result_valid !== 1'b1 || result !== 8'd2 || cnt_clr !== 1'b0) hold_bad++;
    end
    total++; if (hold_bad !== 0) begin
      bad++; $display("FAIL bp_hold: unsteady cycles got %0d want 0", hold_bad);
    end
    result_ready = 1'b1;
    tick;
    total++; if ({result_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL bp_release: valid/busy got %b want 00", {result_valid, busy});
    end
    tick; tick;
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL bp_start_ignored: busy got %b want 0", busy);
    end
  endtask

  task automatic test_unstable;
    int vk;
    vk = -1;
    result_ready = 1'b0; unstable_mode = 1'b1;
    window = 16'd3; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 40 && vk < 0; k++) begin
      tick;
      if (result_valid) vk = k;
    end
    total++; if (vk !== 11) begin
      bad++; $display("FAIL unst_valid_edge: got E%0d want E11", vk);
    end
    total++; if (unstable !== 1'b1) begin
      bad++; $display("FAIL unst_flag: got %b want 1", unstable);
    end
    total++; if (result !== 8'd9) begin
      bad++; $display("FAIL unst_result: got %0h want 9", result);
    end
    result_ready = 1'b1;
    tick;
    unstable_mode = 1'b0;
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL unst_exit: busy got %b want 0", busy);
    end
  endtask

  task automatic test_abort;
    result_ready = 1'b1;
    window = 16'd10; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick;
    total++; if (cnt_gate !== 1'b1) begin
      bad++; $display("FAIL abort_pre_gate: got %b want 1", cnt_gate);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++; if ({cnt_gate, busy, result_valid} !== 3'b000) begin
      bad++; $display("FAIL abort_drop: gate/busy/valid got %b want 000", {cnt_gate, busy, result_valid});
    end
    total++; if (result !== 8'd9 || unstable !== 1'b1) begin
      bad++; $display("FAIL abort_result_kept: got %0h/%b want 9/1", result, unstable);
    end
    start = 1'b1; abort = 1'b1; window = 16'd4;
    tick;
    start = 1'b0; abort = 1'b0;
    total++; if ({busy, cnt_clr} !== 2'b00) begin
      bad++; $display("FAIL abort_start_idle: busy/clr got %b want 00", {busy, cnt_clr});
    end
    tick;
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL abort_stays_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_async_reset;
    int vk;
    vk = -1;
    result_ready = 1'b1;
    window = 16'd10; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    total++; if (cnt_gate !== 1'b1) begin
      bad++; $display("FAIL arst_pre_gate: got %b want 1", cnt_gate);
    end
    #3;
    reset = 1'b0;
    #1;
    total++; if ({cnt_gate, busy, result_valid} !== 3'b000) begin
      bad++; $display("FAIL arst_immediate: gate/busy/valid got %b want 000", {cnt_gate, busy, result_valid});
    end
    total++; if (result !== 8'd0 || unstable !== 1'b0) begin
      bad++; $display("FAIL arst_result: got %0h/%b want 0/0", result, unstable);
    end
    #2;
    reset = 1'b1;
    tick;
    window = 16'd4; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 30 && vk < 0; k++) begin
      tick;
      if (result_valid) vk = k;
    end
    total++; if (vk !== 9) begin
      bad++; $display("FAIL arst_rerun_edge: got E%0d want E9", vk);
    end
    total++; if (result !== 8'd4 || unstable !== 1'b0) begin
      bad++; $display("FAIL arst_rerun_result: got %0h/%b want 4/0", result, unstable);
    end
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_basic;
    test_zero_window;
    test_backpressure;
    test_unstable;
    test_abort;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
